// File: rtl/timer_bank.sv
// N-channel programmable interval timer with prescaler, sticky W1C pending flag and toggle output.
// Register window: 4 words per channel, addressed as {channel, reg[1:0]}.
module timer_bank #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned CNT_W = 32,
  localparam int unsigned AW    = $clog2(N_CH) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wd,
  output logic [31:0]   rd,
  output logic [N_CH-1:0] irq,
  output logic          irq_any,
  output logic [N_CH-1:0] tout
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, FIRE} state_t;

  int unsigned                 ch_idx;
  logic [CH_W-1:0]             ch_sel;
  logic [1:0]                  rsel;
  logic [N_CH-1:0][3:0][31:0]  ch_rd;
  logic                        unused_wd;

  assign ch_idx    = 32'(addr >> 2);
  assign ch_sel    = CH_W'(ch_idx);
  assign rsel      = addr[1:0];
  assign unused_wd = ^{wd[31:16], wd[7:5]};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic             en, im, tog, pend, tout_q;
    logic [1:0]       mode;
    logic [7:0]       psc, psc_cnt;
    logic [CNT_W-1:0] preset, count;
    logic             sel, wr_ctrl, wr_preset, wr_status;
    logic             run, tick;

    assign sel       = we && (ch_idx == i);
    assign wr_ctrl   = sel && (rsel == 2'd0);
    assign wr_preset = sel && (rsel == 2'd1);
    assign wr_status = sel && (rsel == 2'd3);

    // Next-state logic; a CTRL rewrite with EN=1 during counting restarts through LOAD
    always_comb begin
      state_nxt = state;
      run       = 1'b0;
      tick      = 1'b0;
      case (state)
        IDLE: if (en) state_nxt = LOAD;
        LOAD: state_nxt = en ? CNT : IDLE;
        CNT: begin
          if (!en) begin
            state_nxt = IDLE;
          end else if (wr_ctrl && wd[0]) begin
            state_nxt = LOAD;
          end else begin
            run  = 1'b1;
            tick = (psc_cnt == psc);
            if (tick && (count <= CNT_W'(1))) state_nxt = FIRE;
          end
        end
        FIRE:    state_nxt = (en && (mode == 2'd1)) ? LOAD : IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
    end

    // Datapath: config registers, counter/prescaler, pending flag, toggle output
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        en      <= 1'b0;
        mode    <= 2'd0;
        im      <= 1'b0;
        tog     <= 1'b0;
        psc     <= 8'd0;
        preset  <= '0;
        count   <= '0;
        psc_cnt <= 8'd0;
        pend    <= 1'b0;
        tout_q  <= 1'b0;
      end else begin
        if (wr_ctrl) begin
          en   <= wd[0];
          mode <= wd[2:1];
          im   <= wd[3];
          tog  <= wd[4];
          psc  <= wd[15:8];
        end else if ((state == FIRE) && (mode != 2'd1)) begin
          en <= 1'b0;
        end

        if (wr_preset) preset <= wd[CNT_W-1:0];

        if (state == LOAD) begin
          count   <= preset;
          psc_cnt <= 8'd0;
        end else if (run) begin
          psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
          if (tick) count <= (count > CNT_W'(1)) ? count - CNT_W'(1) : '0;
        end

        // Setting on FIRE takes priority over a simultaneous W1C
        if (state == FIRE)              pend <= 1'b1;
        else if (wr_status && wd[0])    pend <= 1'b0;

        if ((state == FIRE) && tog) tout_q <= ~tout_q;
      end
    end

    assign ch_rd[i] = {{31'd0, pend}, 32'(count), 32'(preset),
                       {16'd0, psc, 3'd0, tog, im, mode, en}};
    assign irq[i]   = pend & im;
    assign tout[i]  = tout_q;
  end

  always_comb begin
    rd = 32'd0;
    if (ch_idx < N_CH) rd = ch_rd[ch_sel][rsel];
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register map, one-shot, auto-reload/toggle, prescaler,
// W1C race, disable mid-count and asynchronous reset.
module tb_timer_bank;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned AW    = $clog2(N_CH) + 2;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   addr;
  logic            we;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic [N_CH-1:0] irq;
  logic            irq_any;
  logic [N_CH-1:0] tout;

  int n_checks = 0;
  int n_fail   = 0;

  timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .irq     (irq),
    .irq_any (irq_any),
    .tout    (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  // Channel 2 COUNT after edge k of the PRESET=2, PSC=3, auto-reload run
  function automatic logic [31:0] psc_count(input int k);
    int m;
    if (k < 2) return 32'd0;
    m = (k - 2) % 10;
    if (m < 4) return 32'd2;
    if (m < 8) return 32'd1;
    return 32'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int os_cnt [8] = '{0, 5, 4, 3, 2, 1, 0, 0};

    reset = 1'b1;
    addr  = '0;
    we    = 1'b0;
    wd    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq_any", 32'(irq_any), 32'd0);
    check("rst_tout", 32'(tout), 32'd0);
    reset = 1'b0;

    // Register map after reset, invalid channel, read-only COUNT
    for (int a = 0; a < 4 * N_CH; a++) rd_chk("map_zero", AW'(a), 32'd0);
    for (int a = 4 * N_CH; a < 16; a++) rd_chk("bad_ch_rd", AW'(a), 32'd0);
    wr(AW'(2), 32'hFFFF);
    rd_chk("count_ro", AW'(2), 32'd0);
    wr(AW'(12), 32'h9);
    rd_chk("bad_ch_wr", AW'(12), 32'd0);
    check("map_irq_any", 32'(irq_any), 32'd0);

    // One-shot on channel 0: PRESET=5, CTRL=EN|IM
    wr(AW'(1), 32'd5);
    wr(AW'(0), 32'h9);
    addr = AW'(2);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("os_count", rd, 32'(os_cnt[k-1]));
      check("os_irq", 32'(irq[0]), 32'(k == 8));
    end
    rd_chk("os_ctrl_en_clr", AW'(0), 32'h8);
    rd_chk("os_count_end", AW'(2), 32'd0);
    rd_chk("os_pend", AW'(3), 32'd1);
    check("os_irq_any", 32'(irq_any), 32'd1);
    wr(AW'(3), 32'd1);
    rd_chk("os_w1c", AW'(3), 32'd0);

    // Auto-reload with toggle on channel 1: PRESET=3 -> period 5
    wr(AW'(5), 32'd3);
    wr(AW'(4), 32'h1B);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk);
      #1;
      check("rl_tout", 32'(tout[1]), (k < 6) ? 32'd0 : 32'(((k - 6) / 5) % 2 == 0));
      check("rl_irq", 32'(irq[1]), 32'(k >= 6));
    end
    wr(AW'(4), 32'h0);
    rd_chk("rl_pend_held", AW'(7), 32'd1);
    wr(AW'(7), 32'd1);
    rd_chk("rl_w1c", AW'(7), 32'd0);

    // Prescaler on channel 2: PRESET=2, PSC=3, MODE1, IM=0
    wr(AW'(9), 32'd2);
    wr(AW'(8), 32'h303);
    addr = AW'(10);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check("psc_count", rd, psc_count(k));
      check("psc_irq_masked", 32'(irq[2]), 32'd0);
    end
    wr(AW'(11), 32'd1);
    rd_chk("psc_pend_clr", AW'(11), 32'd0);
    addr = AW'(10);
    for (int k = 14; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check("psc_count", rd, psc_count(k));
    end

    // W1C on the FIRE edge loses to the set; one cycle later it clears
    wr(AW'(11), 32'd1);
    check("w1c_race_set", rd, 32'd1);
    wr(AW'(11), 32'd1);
    check("w1c_after", rd, 32'd0);
    check("w1c_irq_any", 32'(irq_any), 32'd0);

    // Disable channel 2 one cycle into counting: COUNT freezes at 2
    wr(AW'(8), 32'h302);
    repeat (6) @(posedge clk);
    #1;
    rd_chk("dis_count", AW'(10), 32'd2);
    rd_chk("dis_ctrl", AW'(8), 32'h302);
    repeat (4) @(posedge clk);
    #1;
    rd_chk("dis_count_hold", AW'(10), 32'd2);

    // Asynchronous reset mid-count on channel 1 after its first fire
    wr(AW'(4), 32'h1B);
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_irq_any", 32'(irq_any), 32'd1);
    check("pre_rst_tout", 32'(tout), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_irq_any", 32'(irq_any), 32'd0);
    check("arst_tout", 32'(tout), 32'd0);
    addr = AW'(6);
    #1;
    check("arst_count", rd, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_chk("arst_ctrl1", AW'(4), 32'd0);
    rd_chk("arst_preset0", AW'(1), 32'd0);
    rd_chk("arst_ctrl2", AW'(8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
